fp_mant_mul_seq: RTL and testbench

Sequential radix-2 shift-and-add multiplier for two 24-bit significands (hidden bit included). It is the stage directly upstream of the 26-bit adder: every iteration it supplies the adder's operands, then consumes the adder's sum and carry. It instantiates exactly one add_26bits as its only arithmetic element. Its 48-bit product and a pass-through sideband tag (sign plus biased exponent sum) feed the downstream normalise/round stage.

---
 rtl/fp_mant_mul_seq_if.sv | 27 ++
 rtl/fp_mant_mul_seq.sv | 127 ++++++++++++
 tb/tb_fp_mant_mul_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mant_mul_seq_if.sv
// Handshake and data bundle for the sequential significand multiplier.
// The slave modport is the multiplier's view; master is the upstream/downstream side.
interface fp_mant_mul_seq_if #(
    parameter int MANT_W = 24,
    parameter int TAG_W  = 10
);
    logic                  i_valid;
    logic                  o_ready;
    logic [MANT_W-1:0]     i_mant_a;
    logic [MANT_W-1:0]     i_mant_b;
    logic [TAG_W-1:0]      i_tag;
    logic                  o_valid;
    logic                  i_ready;
    logic [2*MANT_W-1:0]   o_product;
    logic [TAG_W-1:0]      o_tag;
    logic                  o_msb;

    modport master (
        output i_valid, i_mant_a, i_mant_b, i_tag, i_ready,
        input  o_ready, o_valid, o_product, o_tag, o_msb
    );

    modport slave (
        input  i_valid, i_mant_a, i_mant_b, i_tag, i_ready,
        output o_ready, o_valid, o_product, o_tag, o_msb
    );
endinterface

// File: rtl/fp_mant_mul_seq.sv
// Radix-2 shift-and-add multiplier for 24-bit significands, one add_26bits per iteration,
// 24 iterations per product, with a pass-through sign/exponent tag.
module add_26bits (
    input  logic [25:0] i_a,
    input  logic [25:0] i_b,
    input  logic        i_carry,
    output logic [25:0] o_data,
    output logic        o_carry
);
    assign {o_carry, o_data} = {1'b0, i_a} + {1'b0, i_b} + {26'b0, i_carry};
endmodule

module fp_mant_mul_seq #(
    parameter int MANT_W = 24,  // only 24: the adder is fixed at MANT_W+2 bits
    parameter int TAG_W  = 10
) (
    input logic              i_clk,
    input logic              i_rst_n,
    fp_mant_mul_seq_if.slave bus
);
    localparam int         ACC_W     = MANT_W + 2;
    localparam int         PROD_W    = 2 * MANT_W;
    localparam logic [4:0] LAST_ITER = 5'(MANT_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [MANT_W-1:0]   m_q, m_d;
    logic [MANT_W-1:0]   q_q, q_d;
    logic [ACC_W-1:0]    a_q, a_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [TAG_W-1:0]    otag_q, otag_d;
    logic                msb_q, msb_d;

    logic [ACC_W-1:0]        add_b;
    logic [ACC_W-1:0]        sum;
    logic                    add_carry;
    logic [ACC_W+MANT_W-1:0] shifted;

    assign add_b = q_q[0] ? {2'b00, m_q} : '0;

    add_26bits u_add (
        .i_a     (a_q),
        .i_b     (add_b),
        .i_carry (1'b0),
        .o_data  (sum),
        .o_carry (add_carry)
    );

    // {carry, sum, Q} >> 1 with the dropped Q[0]; carry is zero by range, so this is {sum, Q} >> 1.
    assign shifted = {add_carry, sum, q_q[MANT_W-1:1]};

    // NOTE: every signal assigned here gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        a_d     = a_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        otag_d  = otag_q;
        msb_d   = msb_q;

        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    state_d = CALC;
                    m_d     = bus.i_mant_a;
                    q_d     = bus.i_mant_b;
                    a_d     = '0;
                    tag_d   = bus.i_tag;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                a_d   = shifted[ACC_W+MANT_W-1:MANT_W];
                q_d   = shifted[MANT_W-1:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    prod_d  = shifted[PROD_W-1:0];
                    msb_d   = shifted[PROD_W-1];
                    otag_d  = tag_q;
                end
            end
            DONE: begin
                if (bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the synchronous reset clears the
    // datapath as well as the FSM so a discarded operation leaves nothing visible behind.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            a_q     <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            otag_q  <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            a_q     <= a_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            otag_q  <= otag_d;
            msb_q   <= msb_d;
        end
    end

    assign bus.o_ready   = (state_q == IDLE);
    assign bus.o_valid   = (state_q == DONE);
    assign bus.o_product = prod_q;
    assign bus.o_tag     = otag_q;
    assign bus.o_msb     = msb_q;
endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Scoreboard bench for fp_mant_mul_seq: the driver queues model products at acceptance,
// a negedge monitor compares them (plus latency and hold behaviour) whenever o_valid is high.
module tb_fp_mant_mul_seq;
    localparam int TAG_W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mant_mul_seq_if #(.MANT_W(24), .TAG_W(TAG_W)) bus ();

    fp_mant_mul_seq #(.MANT_W(24), .TAG_W(TAG_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [47:0]      product;
        logic [TAG_W-1:0] tag;
        int               accept_cyc;
    } exp_t;

    exp_t             sb[$];
    int               vectors     = 0;
    int               miscompares = 0;
    int               cyc         = 0;
    int               results     = 0;
    int               expected_results = 0;
    bit               mon_en      = 1'b0;
    bit               seen_valid  = 1'b0;
    bit               rdy_rand    = 1'b0;
    bit               rdy_force   = 1'b1;
    logic [47:0]      last_prod   = '0;
    logic [TAG_W-1:0] last_tag    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: compares outputs against the scoreboard head or the last handed-off values.
    always @(negedge clk) begin
        if (mon_en) begin
            check("adder_carry", 64'(dut.u_add.o_carry), 64'd0);
            if (bus.o_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: o_valid=1 with product 0x%0h, required no result", bus.o_product);
                end else begin
                    if (!seen_valid) begin
                        check("latency", 64'(cyc - sb[0].accept_cyc), 64'd24);
                        seen_valid = 1'b1;
                    end
                    check("product", 64'(bus.o_product), 64'(sb[0].product));
                    check("tag", 64'(bus.o_tag), 64'(sb[0].tag));
                    check("msb", 64'(bus.o_msb), 64'(sb[0].product[47]));
                    check("ready_in_done", 64'(bus.o_ready), 64'd0);
                    if (bus.i_ready) begin
                        last_prod  = sb[0].product;
                        last_tag   = sb[0].tag;
                        void'(sb.pop_front());
                        seen_valid = 1'b0;
                        results++;
                    end
                end
            end else begin
                check("held_product", 64'(bus.o_product), 64'(last_prod));
                check("held_tag", 64'(bus.o_tag), 64'(last_tag));
                check("held_msb", 64'(bus.o_msb), 64'(last_prod[47]));
            end
        end
    end

    task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [TAG_W-1:0] t);
        int n = 0;
        while (!bus.o_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.o_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: o_ready=0 after %0d cycles, required 1", n);
            return;
        end
        bus.i_valid  = 1'b1;
        bus.i_mant_a = a;
        bus.i_mant_b = b;
        bus.i_tag    = t;
        tick();
        sb.push_back('{product: {24'b0, a} * {24'b0, b}, tag: t, accept_cyc: cyc});
        expected_results++;
        bus.i_valid  = 1'b0;
        bus.i_mant_a = 24'($urandom);
        bus.i_mant_b = 24'($urandom);
        bus.i_tag    = TAG_W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
        end
    endtask

    initial begin
        int n;
        bus.i_valid  = 1'b0;
        bus.i_mant_a = '0;
        bus.i_mant_b = '0;
        bus.i_tag    = '0;
        rst_n        = 1'b0;
        tick(3);
        check("rst_ready", 64'(bus.o_ready), 64'd1);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_product", 64'(bus.o_product), 64'd0);
        check("rst_tag", 64'(bus.o_tag), 64'd0);
        check("rst_msb", 64'(bus.o_msb), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        issue(24'h800000, 24'h800000, 10'h155);
        drain();
        check("dir_1x1_product", 64'(bus.o_product), 64'h4000_0000_0000);
        check("dir_1x1_tag", 64'(bus.o_tag), 64'h155);
        check("dir_1x1_msb", 64'(bus.o_msb), 64'd0);

        issue(24'hC00000, 24'hC00000, 10'h2AA);
        drain();
        check("dir_1p5_product", 64'(bus.o_product), 64'h9000_0000_0000);
        check("dir_1p5_msb", 64'(bus.o_msb), 64'd1);

        issue(24'hFFFFFF, 24'hFFFFFF, 10'h3FF);
        drain();
        check("dir_max_product", 64'(bus.o_product), 64'hFFFF_FE00_0001);
        check("dir_max_msb", 64'(bus.o_msb), 64'd1);

        issue(24'h000000, 24'hFFFFFF, 10'h001);
        drain();
        check("dir_zero_product", 64'(bus.o_product), 64'd0);
        check("dir_zero_msb", 64'(bus.o_msb), 64'd0);

        // Backpressure: hold the result for 7 cycles, then release.
        rdy_force = 1'b0;
        issue(24'hC00000, 24'hA00000, 10'h0F0);
        n = 0;
        while (!bus.o_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_valid_seen", 64'(bus.o_valid), 64'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("bp_valid_held", 64'(bus.o_valid), 64'd1);
            check("bp_ready_low", 64'(bus.o_ready), 64'd0);
        end
        rdy_force = 1'b1;
        tick();
        check("bp_valid_until_edge", 64'(bus.o_valid), 64'd1);
        tick();
        check("bp_release_ready", 64'(bus.o_ready), 64'd1);
        check("bp_release_valid", 64'(bus.o_valid), 64'd0);
        check("bp_product", 64'(bus.o_product), 64'h7800_0000_0000);

        // Busy-ignore: a request during CALC must not start a second operation.
        issue(24'h900000, 24'h900000, 10'h0AA);
        tick(5);
        bus.i_valid  = 1'b1;
        bus.i_mant_a = 24'h123456;
        bus.i_mant_b = 24'hABCDEF;
        bus.i_tag    = 10'h3C3;
        tick();
        bus.i_valid  = 1'b0;
        drain();
        tick(40);
        check("busy_product", 64'(bus.o_product), 64'h5100_0000_0000);
        check("busy_tag", 64'(bus.o_tag), 64'h0AA);

        // Reset at cnt = 10 discards the in-flight operation.
        issue(24'hFFFFFF, 24'hABCDEF, 10'h123);
        tick(10);
        rst_n = 1'b0;
        tick();
        sb.delete();
        expected_results--;
        seen_valid = 1'b0;
        last_prod  = '0;
        last_tag   = '0;
        rst_n      = 1'b1;
        check("midrst_ready", 64'(bus.o_ready), 64'd1);
        check("midrst_valid", 64'(bus.o_valid), 64'd0);
        check("midrst_product", 64'(bus.o_product), 64'd0);
        issue(24'h800000, 24'hA00000, 10'h2C1);
        drain();
        check("post_rst_product", 64'(bus.o_product), 64'h5000_0000_0000);

        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            issue(24'($urandom), 24'($urandom), TAG_W'($urandom));
        end
        drain();
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        tick(40);
        check("result_count", 64'(results), 64'(expected_results));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
